// File: rtl/if_stage.sv
// if_stage: instruction fetch from a fetch queue into a single output register, with redirect, bus-fault and illegal handling.
// Compressed (16-bit) parcels are supported only when IF_STAGE_RVC_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp_req,
    input  logic [31:0] jmp_addr,
    input  logic [1:0]  vld_size,
    input  logic [31:0] data,
    input  logic        bus_err,
    output logic        pop,
    output logic [1:0]  pop_size,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_c,
    output logic        out_fault,
    output logic        out_ill
);
`ifdef IF_STAGE_RVC_EN
    localparam logic RVC = 1'b1;
`else
    localparam logic RVC = 1'b0;
`endif
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [31:0] pc_q, pc_d, out_instr_q, out_instr_d, out_pc_q, out_pc_d;
    logic [0:0]  state_q, state_d;
    logic        out_vld_q, out_vld_d, out_c_q, out_c_d;
    logic        out_fault_q, out_fault_d, out_ill_q, out_ill_d;
    logic        free, is32, avail, run_ok, misalign, issue;

    assign free     = !out_vld_q || out_rdy;
    assign is32     = data[1:0] == 2'b11;
    assign avail    = RVC ? (is32 ? vld_size[1] : |vld_size) : vld_size[1];
    assign run_ok   = free && state_q == RUN && !jmp_req;
    // Without RVC a pc with bit 1 set can never hold a legal instruction.
    assign misalign = !RVC && pc_q[1];
    assign issue    = run_ok && !bus_err && !misalign && avail;
    assign pop      = issue && !rst;
    assign pop_size = (RVC && !is32) ? 2'b01 : 2'b10;

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        out_vld_d   = out_vld_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_c_d     = out_c_q;
        out_fault_d = out_fault_q;
        out_ill_d   = out_ill_q;
        if (jmp_req) begin
            out_vld_d = 1'b0;
            pc_d      = {jmp_addr[31:1], 1'b0};
            state_d   = RUN;
        end else if (issue) begin
            out_vld_d   = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = (RVC && !is32) ? {16'h0000, data[15:0]} : data;
            out_c_d     = RVC && !is32;
            out_fault_d = 1'b0;
            out_ill_d   = !RVC && !is32;
            pc_d        = pc_q + ((RVC && !is32) ? 32'd2 : 32'd4);
        end else if (run_ok && (misalign || bus_err)) begin
            out_vld_d   = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = 32'h0;
            out_c_d     = 1'b0;
            out_fault_d = !misalign;
            out_ill_d   = misalign;
            state_d     = HOLD;
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            state_q     <= RUN;
            out_vld_q   <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 32'h0;
            out_c_q     <= 1'b0;
            out_fault_q <= 1'b0;
            out_ill_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            out_vld_q   <= out_vld_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_c_q     <= out_c_d;
            out_fault_q <= out_fault_d;
            out_ill_q   <= out_ill_d;
        end
    end

    assign out_vld   = out_vld_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign out_c     = out_c_q;
    assign out_fault = out_fault_q;
    assign out_ill   = out_ill_q;
endmodule
